rom_seq_reader: RTL



---
 rtl/rom_seq_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rom_seq_reader.sv
// -----------------------------------------------------------------------------
// rom_seq_reader
//
// Sequencing reader for a small lookup ROM. A start pulse in IDLE walks the
// ROM from address 0 to LAST_ADDR. Each word is fetched with a one-cycle read
// enable, registered, and offered downstream on a valid/ready handshake. When
// loop is high at the transfer of the LAST_ADDR word, the walk restarts at
// address 0. Otherwise done pulses and the reader returns to IDLE.
//
// Optional feature (compile-time macro ROM_SEQ_READER_CHKSUM_EN):
//   defined   - chksum is a modulo-2^DATA_W running sum of transferred words.
//   undefined - the checksum logic is absent and chksum is tied to 0.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       begin a pass (sampled only in IDLE)
//   loop        wrap to address 0 at the last word instead of finishing
//   rom_addr    ROM address (the internal address register)
//   rom_rd_en   ROM read enable, high only while fetching
//   rom_data    ROM read data (combinational from rom_addr)
//   dout        registered word to downstream
//   dout_valid  dout holds an unaccepted word
//   dout_ready  downstream accept
//   busy        a pass is in progress
//   done        one-cycle pulse after the final word of a non-looping pass
//   chksum      running checksum (see the macro above)
// -----------------------------------------------------------------------------
module rom_seq_reader #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int LAST_ADDR = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] chksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic              valid_q;
    logic              rd_en_q;
    logic              busy_q;
    logic              done_q;

    // A transfer can only happen in HOLD, where valid_q is always set; the
    // state term keeps the intent explicit.
    logic transfer;
    logic at_last;
    assign transfer = (state_q == HOLD) && valid_q && dout_ready;
    assign at_last  = (addr_q == LAST);

    // All outputs are direct register copies, so dout_ready never reaches an
    // output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q  <= '0;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    dout_q  <= rom_data;
                    valid_q <= 1'b1;
                    rd_en_q <= 1'b0;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (transfer) begin
                        valid_q <= 1'b0;
                        if (!at_last) begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            rd_en_q <= 1'b1;
                            state_q <= FETCH;
                        end else if (loop) begin
                            addr_q  <= '0;
                            rd_en_q <= 1'b1;
                            state_q <= FETCH;
                        end else begin
                            // addr_q deliberately stays at LAST.
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROM_SEQ_READER_CHKSUM_EN
    logic [DATA_W-1:0] chksum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chksum_q <= '0;
        end else if (state_q == IDLE && start) begin
            chksum_q <= '0;
        end else if (transfer) begin
            chksum_q <= chksum_q + dout_q;
        end
    end

    assign chksum = chksum_q;
`else
    assign chksum = '0;
`endif

    assign rom_addr   = addr_q;
    assign rom_rd_en  = rd_en_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
